piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits, legal values 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends pin[WIDTH-1] first, 0 sends pin[0] first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  request to capture pin; honoured only in IDLE.
REQ-006 pin  input  WIDTH  parallel word from upstream PIPO register (its pout).
REQ-007 ready  input  1  downstream accepts the current sout bit at this edge.
REQ-008 sout  output  1  serial data bit.
REQ-009 sout_valid  output  1  sout holds a valid bit.
REQ-010 busy  output  1  a word is in flight (state != IDLE).
REQ-011 done  output  1  one-cycle pulse after the final bit is accepted.
REQ-012 ovr  output  1  sticky overrun flag.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and PARITY; PARITY exists only with PISO_PARITY_EN.
REQ-014 IDLE: sout=0, sout_valid=0, busy=0.
REQ-015 IDLE with load=1 at an edge: capture pin into the shift register, set the bit counter to WIDTH-1, clear ovr, go to SHIFT.
REQ-016 Latency: the first bit appears on sout, with sout_valid=1, in the cycle after the capturing edge.
REQ-017 SHIFT: sout = the current head bit (MSB or LSB per MSB_FIRST), sout_valid=1, busy=1.
REQ-018 Edge with sout_valid=1 and ready=1: the bit is consumed, the register shifts toward the head, and the counter decrements.
REQ-019 ready=0: the register, counter, sout and sout_valid SHALL hold unchanged (stall of unlimited length).
REQ-020 Consuming the last data bit (counter=0): go to IDLE (or PARITY when enabled).
REQ-021 done SHALL be a registered pulse, high for exactly one cycle following the edge at which the final bit (data or parity) is consumed.
REQ-022 load=1 at an edge while busy=1: pin ignored, stream unaffected, ovr set to 1; ovr stays 1 until the next accepted load clears it.
REQ-023 Back-to-back words: load in the done cycle SHALL be accepted, giving a minimum one-cycle gap (sout_valid=0) between words.
REQ-024 All outputs SHALL be driven from registers or the FSM state only; no combinational path from inputs to outputs.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, a zero shift register, counter 0, sout=0, sout_valid=0, busy=0, done=0 and ovr=0, regardless of clk.
REQ-026 Reset asserted mid-word SHALL discard the word; after release the block waits in IDLE for a new load.
REQ-027 Reset release is synchronised by the system; the block samples nothing in the release cycle beyond normal edge behaviour.

Configuration
REQ-028 Macro PISO_PARITY_EN defined: even parity of the captured word is computed at load and sent as bit WIDTH+1 in state PARITY (sout_valid=1, honours ready); done follows its acceptance.
REQ-029 PISO_PARITY_EN undefined: no PARITY state or parity logic; a word is exactly WIDTH bits.

Verification
REQ-030 Assert rst_n=0 mid-run -> all outputs 0 asynchronously; no sout_valid until a new load.
REQ-031 WIDTH=4, MSB_FIRST=1, ready=1, load pin=4'b1010 -> sout 1,0,1,0 on four consecutive valid cycles, then done=1 for one cycle, busy=0.
REQ-032 pin=4'b1100, ready low for 3 cycles after the second bit -> sout stays 1 with sout_valid=1 through the stall; sequence completes 1,1,0,0.
REQ-033 Load 4'b1010, then load 4'b0110 while busy -> ovr=1, stream still 1,0,1,0; the next load in IDLE clears ovr.
REQ-034 Load 4'b0011, then load 4'b0101 in the done cycle -> both words sent intact with exactly one idle cycle between them.
REQ-035 PISO_PARITY_EN defined, pin=4'b1101 -> sout 1,1,0,1,1 (parity 1), then the done pulse.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Handshake and data bundle between an upstream PIPO register, the
// piso_serializer and the downstream serial consumer.
// The slave modport is the serializer's view and the master modport is the
// driving side's view.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] pin;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;
    logic             ovr;

    modport slave (
        input  load,
        input  pin,
        input  ready,
        output sout,
        output sout_valid,
        output busy,
        output done,
        output ovr
    );

    modport master (
        output load,
        output pin,
        output ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  done,
        input  ovr
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a ready/valid serial side.
// It captures a WIDTH-bit word on load while idle and emits it one bit per
// accepted cycle, MSB or LSB first. It pulses done after the final bit and
// flags overrun (ovr) when a load arrives mid-word.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit after
// the data bits.
// All outputs come from flops or the state register, so no input reaches an
// output combinationally.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    piso_serializer_if.slave      bus
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // The head is the bit currently presented on sout.
    function automatic logic head_bit(input logic [WIDTH-1:0] r);
        return MSB_FIRST ? r[WIDTH-1] : r[0];
    endfunction

    // Move the next bit into the head position, filling with zero.
    function automatic logic [WIDTH-1:0] shift_toward_head(input logic [WIDTH-1:0] r);
        return MSB_FIRST ? {r[WIDTH-2:0], 1'b0} : {1'b0, r[WIDTH-1:1]};
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        ovr_d        = ovr_q;
        done_d       = 1'b0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shreg_d = bus.pin;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    ovr_d   = 1'b0;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    parity_d = ^bus.pin;
`endif
                end
            end
            SHIFT: begin
                if (bus.load) begin
                    ovr_d = 1'b1;
                end
                if (bus.ready) begin
                    shreg_d = shift_toward_head(shreg_q);
                    if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (bus.load) begin
                    ovr_d = 1'b1;
                end
                if (bus.ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            SHIFT: begin
                sout_d       = head_bit(shreg_d);
                sout_valid_d = 1'b1;
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                sout_d       = parity_d;
                sout_valid_d = 1'b1;
            end
`endif
            default: begin
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
`ifdef PISO_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=4, MSB first).
// Each check compares the packed output vector
// {sout, sout_valid, busy, done, ovr} against a hand-computed constant.
module tb_piso_serializer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    piso_serializer_if #(.WIDTH(4)) bus ();

    piso_serializer #(
        .WIDTH    (4),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the inputs, then advance one rising edge and settle 1 ns past it.
    task automatic applyStimulus(input logic l, input logic [3:0] p, input logic r);
        bus.load  = l;
        bus.pin   = p;
        bus.ready = r;
        @(posedge clk);
        #1;
    endtask

    // Compare {sout, sout_valid, busy, done, ovr} with the expected pattern.
    task automatic checkOutput(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bus.sout, bus.sout_valid, bus.busy, bus.done, bus.ovr};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b (sout,valid,busy,done,ovr)", tag, obs, exp);
        end
    endtask

    // Linear directed sequence covering reset, streaming, stall, overrun,
    // back-to-back words and reset in the middle of a word.
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.pin   = 4'b0000;
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("reset_state", 5'b00000);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("idle_after_reset", 5'b00000);

        $display("[TB] Word 1010, ready held high");
        applyStimulus(1'b1, 4'b1010, 1'b1);
        checkOutput("w1010_b0", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1010_b1", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1010_b2", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1010_b3", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1010_done", 5'b00010);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1010_done_drop", 5'b00000);

        $display("[TB] Word 1100 with a three-cycle stall on bit 1");
        applyStimulus(1'b1, 4'b1100, 1'b1);
        checkOutput("w1100_b0", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1100_b1", 5'b11100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b0);
            checkOutput("w1100_stall", 5'b11100);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1100_b2", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1100_b3", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1100_done", 5'b00010);

        $display("[TB] Overrun: load 0110 while 1010 is in flight");
        applyStimulus(1'b1, 4'b1010, 1'b1);
        checkOutput("ovr_b0", 5'b11100);
        applyStimulus(1'b1, 4'b0110, 1'b1);
        checkOutput("ovr_b1", 5'b01101);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("ovr_b2", 5'b11101);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("ovr_b3", 5'b01101);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("ovr_done_sticky", 5'b00011);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("ovr_idle_sticky", 5'b00001);
        applyStimulus(1'b1, 4'b1000, 1'b1);
        checkOutput("ovr_cleared_b0", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1000_b1", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1000_b2", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1000_b3", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("w1000_done", 5'b00010);

        $display("[TB] Back-to-back: 0011 then 0101 loaded in the done cycle");
        applyStimulus(1'b1, 4'b0011, 1'b1);
        checkOutput("b2b_a0", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_a1", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_a2", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_a3", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_gap_done", 5'b00010);
        applyStimulus(1'b1, 4'b0101, 1'b1);
        checkOutput("b2b_b0", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_b1", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_b2", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_b3", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_done", 5'b00010);

        $display("[TB] Reset asserted in the middle of word 1111");
        applyStimulus(1'b1, 4'b1111, 1'b1);
        checkOutput("rst_mid_b0", 5'b11100);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("rst_mid_b1_ovr", 5'b11101);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 5'b00000);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1);
            checkOutput("rst_wait_idle", 5'b00000);
        end
        applyStimulus(1'b1, 4'b0110, 1'b1);
        checkOutput("post_rst_b0", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("post_rst_b1", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("post_rst_b2", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("post_rst_b3", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("post_rst_done", 5'b00010);

`ifdef PISO_PARITY_EN
        $display("[TB] Parity word 1101");
        applyStimulus(1'b1, 4'b1101, 1'b1);
        checkOutput("par_b0", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("par_b1", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("par_b2", 5'b01100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("par_b3", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("par_bit", 5'b11100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("par_done", 5'b00010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
